mold_header_parser: RTL and testbench
=====================================

# mold_header_parser

Receive-side front end of the MoldUDP64 decoder. It sits directly behind the UDP/Ethernet AXI-Stream source. It registers each incoming beat and tracks header beats h0/h1/h2. It extracts the MoldUDP64 header fields (session, sequence number, message count) and the first message length, and reports the byte count of every registered beat from its thermometer `tkeep`.

## Interface
Parameters:
- `AXI_DATA_W`, 64, stream data width in bits; the header layout below is defined for 64 only.
- `AXI_KEEP_W`, 8, `tkeep` width (AXI_DATA_W/8).
- `ML_W`, 16, message count / message length field width.
- Derived: `AXI_KEEP_LW` = clog2(AXI_KEEP_W)+1 (4).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `upd_axis_tvalid_i`  in  1  beat valid.
- `upd_axis_tkeep_i`  in  AXI_KEEP_W  byte enables, thermometer from bit 0.
- `upd_axis_tdata_i`  in  AXI_DATA_W  beat data, byte n at [8n+7:8n].
- `upd_axis_tlast_i`  in  1  last beat of UDP payload.
- `upd_axis_tuser_i`  in  1  upstream error flag.
- `upd_axis_tready_o`  out  1  constant 1.
- `sid_p0_v_o` / `sid_p0_o`  out  1 / 64  session bytes 0–7.
- `sid_p1_v_o` / `sid_p1_o`  out  1 / 16  session bytes 8–9.
- `seq_num_p0_v_o` / `seq_num_p0_o`  out  1 / 48  sequence bytes 0–5.
- `seq_num_p1_v_o` / `seq_num_p1_o`  out  1 / 16  sequence bytes 6–7.
- `msg_cnt_v_o` / `msg_cnt_o`  out  1 / ML_W  message count.
- `msg_len_v_o` / `msg_len_o`  out  1 / ML_W  first message length.
- `payload_v_o`  out  1  registered beat is a post-header beat.
- `beat_len_o`  out  AXI_KEEP_LW  byte count of registered beat (0–8).
- `beat_last_o`, `beat_err_o`  out  1  registered tlast / tuser, qualified by the registered valid.

## Operation
- Input stage: one register for tvalid/tkeep/tdata/tlast/tuser; all decode works on the registered beat (`_q`).
- Beat-position FSM states, advancing only on a registered valid beat:
  - H0 → H1 → H2 → PAYLOAD.
  - PAYLOAD holds until a valid beat with tlast, then returns to H0.
  - tlast in H0/H1/H2 (runt packet) returns to H0; later header valids of that packet are not raised.
  - Invalid cycles hold the state and drive all `_v_o` low.
- Field extraction from registered tdata. Raw byte lanes, no endianness swap:
  - H0: `sid_p0_o` = tdata[63:0].
  - H1: `sid_p1_o` = [15:0]; `seq_num_p0_o` = [63:16].
  - H2: `seq_num_p1_o` = [15:0]; `msg_cnt_o` = [31:16]; `msg_len_o` = [47:32].
- Valid rules:
  - Each `_v_o` = registered valid AND matching state.
  - `msg_len_v_o` additionally requires tkeep[5] set; otherwise the length field is not present.
- Data outputs may take any value when their valid is low. Extraction logic is purely combinational from the register stage.
- `beat_len_o` = popcount(tkeep_q), for any tkeep pattern.
- `beat_len_o` is 0 when the registered valid is low.
- `payload_v_o` = registered valid AND state PAYLOAD.

## Timing
- Latency: an input beat accepted at edge N is presented on all outputs during cycle N+1 (1 cycle).
- `tready_o` = 1 always, including during reset; no backpressure.
- Reset values:
  - Registered valid 0; FSM state H0.
  - Every `_v_o`, `payload_v_o`, `beat_last_o`, `beat_err_o` = 0; `beat_len_o` = 0.
- Reset mid-packet discards the packet; the first valid beat after reset deasserts is treated as H0.
- The state update and the output decode for a beat are consistent within the same cycle. A valid beat in state PAYLOAD with tlast is followed, next valid beat, by H0; back-to-back packets need no idle cycle.
- `tuser` does not alter FSM flow; it is only reported on `beat_err_o`.

## Test plan
- Reset, then idle: all valids 0, `beat_len_o`=0, `tready_o`=1.
- Three-beat header, each beat tkeep=0xFF:
  - h0 tdata=0x0706050403020100 → cycle+1 `sid_p0_v_o`=1, `sid_p0_o`=0x0706050403020100.
  - h1=0x0F0E0D0C0B0A0908 → `sid_p1_o`=0x0908, `seq_num_p0_o`=0x0F0E0D0C0B0A.
  - h2=0x1716_0020_0003_1110 → `seq_num_p1_o`=0x1110, `msg_cnt_o`=0x0003, `msg_len_o`=0x0020.
- tkeep sweep 0x00, 0x01, 0x03 … 0xFF → `beat_len_o` = 0, 1, 2 … 8 one cycle later.
- Gaps between header beats (tvalid low 2 cycles) → the FSM holds and fields appear only on valid beats.
- Runt packet: two beats with tlast on beat 2 → no `seq_num_p1_v_o`. The next packet's first beat raises `sid_p0_v_o`.
- Payload beats after h2, tkeep=0x0F with tlast and tuser=1 → `payload_v_o`=1, `beat_len_o`=4, `beat_last_o`=1, `beat_err_o`=1. The following valid beat raises `sid_p0_v_o`.

Source files
------------

// File: rtl/mold_header_parser.sv
// mold_header_parser
// Receive-side front end of the MoldUDP64 decoder. Registers each AXI-Stream
// beat and tracks its position in the packet (h0/h1/h2/payload). Decodes the
// MoldUDP64 header fields and the byte count of the registered beat. The
// decode is combinational from the single register stage, so every input beat
// appears on the outputs one cycle after it is accepted.
module mold_header_parser #(
  parameter  int AXI_DATA_W  = 64,
  parameter  int AXI_KEEP_W  = 8,
  parameter  int ML_W        = 16,
  localparam int AXI_KEEP_LW = $clog2(AXI_KEEP_W) + 1
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   upd_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0]  upd_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0]  upd_axis_tdata_i,
  input  logic                   upd_axis_tlast_i,
  input  logic                   upd_axis_tuser_i,
  output logic                   upd_axis_tready_o,

  output logic                   sid_p0_v_o,
  output logic [63:0]            sid_p0_o,
  output logic                   sid_p1_v_o,
  output logic [15:0]            sid_p1_o,
  output logic                   seq_num_p0_v_o,
  output logic [47:0]            seq_num_p0_o,
  output logic                   seq_num_p1_v_o,
  output logic [15:0]            seq_num_p1_o,
  output logic                   msg_cnt_v_o,
  output logic [ML_W-1:0]        msg_cnt_o,
  output logic                   msg_len_v_o,
  output logic [ML_W-1:0]        msg_len_o,

  output logic                   payload_v_o,
  output logic [AXI_KEEP_LW-1:0] beat_len_o,
  output logic                   beat_last_o,
  output logic                   beat_err_o
);

  // Position of the registered beat inside the current UDP payload.
  typedef enum logic [1:0] {
    ST_H0      = 2'd0,
    ST_H1      = 2'd1,
    ST_H2      = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  // Byte lane that carries the upper byte of the first message length.
  localparam int MSG_LEN_KEEP_BIT = 5;

  // Registered copy of the incoming beat.
  logic                  valid_r;
  logic [AXI_KEEP_W-1:0] keep_r;
  logic [AXI_DATA_W-1:0] data_r;
  logic                  last_r;
  logic                  user_r;

  // State describing the beat currently held in the register stage.
  state_t                state_r;

  // Decoded position flags for the registered beat.
  logic                  is_h0_s;
  logic                  is_h1_s;
  logic                  is_h2_s;
  logic                  is_payload_s;
  logic [AXI_KEEP_LW-1:0] keep_cnt_s;

  // Count of set bits in a byte-enable vector; works for any pattern, not
  // only thermometer codes, so a malformed tkeep still reports honestly.
  function automatic logic [AXI_KEEP_LW-1:0] keep_popcount(
    input logic [AXI_KEEP_W-1:0] keep
  );
    logic [AXI_KEEP_LW-1:0] cnt;
    cnt = {AXI_KEEP_LW{1'b0}};
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      cnt = cnt + {{(AXI_KEEP_LW-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

  // The parser never stalls the UDP source.
  assign upd_axis_tready_o = 1'b1;

  // Input register stage: capture every cycle, clear on reset so that a
  // packet in flight is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      keep_r  <= {AXI_KEEP_W{1'b0}};
      data_r  <= {AXI_DATA_W{1'b0}};
      last_r  <= 1'b0;
      user_r  <= 1'b0;
    end else begin
      valid_r <= upd_axis_tvalid_i;
      keep_r  <= upd_axis_tkeep_i;
      data_r  <= upd_axis_tdata_i;
      last_r  <= upd_axis_tlast_i;
      user_r  <= upd_axis_tuser_i;
    end
  end

  // Beat-position FSM: advances once per registered valid beat; tlast in any
  // state (including a runt header) restarts at H0 for the next packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_H0;
    end else if (valid_r) begin
      if (last_r) begin
        state_r <= ST_H0;
      end else begin
        case (state_r)
          ST_H0:      state_r <= ST_H1;
          ST_H1:      state_r <= ST_H2;
          ST_H2:      state_r <= ST_PAYLOAD;
          ST_PAYLOAD: state_r <= ST_PAYLOAD;
          default:    state_r <= ST_H0;
        endcase
      end
    end else begin
      state_r <= state_r;
    end
  end

  // Position decode of the registered beat, qualified by its valid.
  always_comb begin
    is_h0_s      = 1'b0;
    is_h1_s      = 1'b0;
    is_h2_s      = 1'b0;
    is_payload_s = 1'b0;
    if (valid_r) begin
      case (state_r)
        ST_H0:      is_h0_s      = 1'b1;
        ST_H1:      is_h1_s      = 1'b1;
        ST_H2:      is_h2_s      = 1'b1;
        ST_PAYLOAD: is_payload_s = 1'b1;
        default: begin
          is_h0_s      = 1'b0;
          is_h1_s      = 1'b0;
          is_h2_s      = 1'b0;
          is_payload_s = 1'b0;
        end
      endcase
    end else begin
      is_h0_s      = 1'b0;
      is_h1_s      = 1'b0;
      is_h2_s      = 1'b0;
      is_payload_s = 1'b0;
    end
  end

  // Header field extraction: raw byte lanes of the registered data, no swap.
  always_comb begin
    sid_p0_o     = data_r[63:0];
    sid_p1_o     = data_r[15:0];
    seq_num_p0_o = data_r[63:16];
    seq_num_p1_o = data_r[15:0];
    msg_cnt_o    = data_r[16 +: ML_W];
    msg_len_o    = data_r[32 +: ML_W];
  end

  // Field valids: the length field only counts when its bytes are present.
  always_comb begin
    sid_p0_v_o     = is_h0_s;
    sid_p1_v_o     = is_h1_s;
    seq_num_p0_v_o = is_h1_s;
    seq_num_p1_v_o = is_h2_s;
    msg_cnt_v_o    = is_h2_s;
    if (is_h2_s && keep_r[MSG_LEN_KEEP_BIT]) begin
      msg_len_v_o = 1'b1;
    end else begin
      msg_len_v_o = 1'b0;
    end
  end

  // Per-beat reporting: byte count, tlast and error flag of the valid beat.
  always_comb begin
    keep_cnt_s  = keep_popcount(keep_r);
    payload_v_o = is_payload_s;
    if (valid_r) begin
      beat_len_o  = keep_cnt_s;
      beat_last_o = last_r;
      beat_err_o  = user_r;
    end else begin
      beat_len_o  = {AXI_KEEP_LW{1'b0}};
      beat_last_o = 1'b0;
      beat_err_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mold_header_parser.sv
// Self-checking bench for mold_header_parser: directed header/runt/payload
// sequences plus random beats, compared against a packet-position model.
module tb_mold_header_parser;

  logic        clk;
  logic        reset;
  logic        tvalid;
  logic [7:0]  tkeep;
  logic [63:0] tdata;
  logic        tlast;
  logic        tuser;
  logic        tready;
  logic        sid_p0_v;
  logic [63:0] sid_p0;
  logic        sid_p1_v;
  logic [15:0] sid_p1;
  logic        seq_p0_v;
  logic [47:0] seq_p0;
  logic        seq_p1_v;
  logic [15:0] seq_p1;
  logic        msg_cnt_v;
  logic [15:0] msg_cnt;
  logic        msg_len_v;
  logic [15:0] msg_len;
  logic        payload_v;
  logic [3:0]  beat_len;
  logic        beat_last;
  logic        beat_err;

  int checks_cnt;
  int errors_cnt;
  // Number of valid beats already seen in the current packet (saturates at 3).
  int pos_m;

  mold_header_parser dut (
    .clk               (clk),
    .reset             (reset),
    .upd_axis_tvalid_i (tvalid),
    .upd_axis_tkeep_i  (tkeep),
    .upd_axis_tdata_i  (tdata),
    .upd_axis_tlast_i  (tlast),
    .upd_axis_tuser_i  (tuser),
    .upd_axis_tready_o (tready),
    .sid_p0_v_o        (sid_p0_v),
    .sid_p0_o          (sid_p0),
    .sid_p1_v_o        (sid_p1_v),
    .sid_p1_o          (sid_p1),
    .seq_num_p0_v_o    (seq_p0_v),
    .seq_num_p0_o      (seq_p0),
    .seq_num_p1_v_o    (seq_p1_v),
    .seq_num_p1_o      (seq_p1),
    .msg_cnt_v_o       (msg_cnt_v),
    .msg_cnt_o         (msg_cnt),
    .msg_len_v_o       (msg_len_v),
    .msg_len_o         (msg_len),
    .payload_v_o       (payload_v),
    .beat_len_o        (beat_len),
    .beat_last_o       (beat_last),
    .beat_err_o        (beat_err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then check the decode of that beat one cycle on.
  task automatic drive_beat(input logic v, input logic [7:0] keep, input logic [63:0] data,
                            input logic last, input logic user);
    int h;
    @(negedge clk);
    tvalid = v;
    tkeep  = keep;
    tdata  = data;
    tlast  = last;
    tuser  = user;
    @(posedge clk);
    #1;
    h = pos_m;
    check_val("tready",    64'(tready),    64'd1);
    check_val("sid_p0_v",  64'(sid_p0_v),  64'(v && h == 0));
    check_val("sid_p1_v",  64'(sid_p1_v),  64'(v && h == 1));
    check_val("seq_p0_v",  64'(seq_p0_v),  64'(v && h == 1));
    check_val("seq_p1_v",  64'(seq_p1_v),  64'(v && h == 2));
    check_val("msg_cnt_v", 64'(msg_cnt_v), 64'(v && h == 2));
    check_val("msg_len_v", 64'(msg_len_v), 64'(v && h == 2 && keep[5]));
    check_val("payload_v", 64'(payload_v), 64'(v && h >= 3));
    check_val("beat_len",  64'(beat_len),  v ? 64'($countones(keep)) : 64'd0);
    check_val("beat_last", 64'(beat_last), 64'(v && last));
    check_val("beat_err",  64'(beat_err),  64'(v && user));
    if (v && h == 0) check_val("sid_p0", sid_p0, data);
    if (v && h == 1) begin
      check_val("sid_p1", 64'(sid_p1), data & 64'hFFFF);
      check_val("seq_p0", 64'(seq_p0), data >> 16);
    end
    if (v && h == 2) begin
      check_val("seq_p1",  64'(seq_p1),  data & 64'hFFFF);
      check_val("msg_cnt", 64'(msg_cnt), (data >> 16) & 64'hFFFF);
      if (keep[5]) check_val("msg_len", 64'(msg_len), (data >> 32) & 64'hFFFF);
    end
    if (v) begin
      if (last) pos_m = 0;
      else if (pos_m < 3) pos_m = pos_m + 1;
      else pos_m = 3;
    end
  endtask

  // Reset with garbage on the bus; everything must read idle during reset.
  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    tvalid = 1'b1;
    tkeep  = 8'hFF;
    tdata  = 64'hDEAD_BEEF_0000_0001;
    tlast  = 1'b1;
    tuser  = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_tready",    64'(tready),    64'd1);
    check_val("rst_sid_p0_v",  64'(sid_p0_v),  64'd0);
    check_val("rst_sid_p1_v",  64'(sid_p1_v),  64'd0);
    check_val("rst_seq_p0_v",  64'(seq_p0_v),  64'd0);
    check_val("rst_seq_p1_v",  64'(seq_p1_v),  64'd0);
    check_val("rst_msg_cnt_v", 64'(msg_cnt_v), 64'd0);
    check_val("rst_msg_len_v", 64'(msg_len_v), 64'd0);
    check_val("rst_payload_v", 64'(payload_v), 64'd0);
    check_val("rst_beat_len",  64'(beat_len),  64'd0);
    check_val("rst_beat_last", 64'(beat_last), 64'd0);
    check_val("rst_beat_err",  64'(beat_err),  64'd0);
    @(negedge clk);
    reset  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    pos_m  = 0;
  endtask

  initial begin
    logic [8:0] therm;
    checks_cnt = 0;
    errors_cnt = 0;
    pos_m      = 0;
    reset      = 1'b1;
    tvalid     = 1'b0;
    tkeep      = 8'h00;
    tdata      = 64'd0;
    tlast      = 1'b0;
    tuser      = 1'b0;
    repeat (3) @(posedge clk);
    apply_reset();

    // Idle after reset.
    repeat (2) drive_beat(1'b0, 8'h00, 64'd0, 1'b0, 1'b0);

    // Three-beat header, then two payload beats ending with tlast + tuser.
    drive_beat(1'b1, 8'hFF, 64'h0706050403020100, 1'b0, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'h0F0E0D0C0B0A0908, 1'b0, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'h1716_0020_0003_1110, 1'b0, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    drive_beat(1'b1, 8'h0F, 64'h0000_0000_AABB_CCDD, 1'b1, 1'b1);

    // Header with idle gaps; h2 short (no length bytes).
    drive_beat(1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    repeat (2) drive_beat(1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
    repeat (2) drive_beat(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
    drive_beat(1'b1, 8'h1F, 64'h0000_0055_0007_2222, 1'b1, 1'b0);

    // Runt packet: tlast on beat 2, then a fresh packet.
    drive_beat(1'b1, 8'hFF, 64'hA0A0_A0A0_A0A0_A0A0, 1'b0, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'hB0B0_B0B0_B0B0_B0B0, 1'b1, 1'b0);
    drive_beat(1'b1, 8'hFF, 64'hC0C0_C0C0_C0C0_C0C0, 1'b0, 1'b0);

    // tkeep thermometer sweep 0x00..0xFF (also walks the FSM).
    for (int k = 0; k <= 8; k++) begin
      therm = (9'd1 << k) - 9'd1;
      drive_beat(1'b1, therm[7:0], {$urandom, $urandom}, 1'b0, 1'b0);
    end
    drive_beat(1'b1, 8'h03, 64'd5, 1'b1, 1'b0);

    // Random traffic, with a reset dropped into the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) apply_reset();
      drive_beat(($urandom_range(3, 0) != 0), 8'($urandom), {$urandom, $urandom},
                 ($urandom_range(5, 0) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
